// File: rtl/snn_spike_decoder.sv
// snn_spike_decoder: counts output-neuron spikes from snn_network over a
// fixed window, then runs a sequential argmax and reports the winning class.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        request a new window (sampled only when idle)
//   out_spk      spike vector, one bit per output neuron
//   busy         high while counting or comparing
//   result_valid one-cycle pulse when the result fields update
//   winner       index of the neuron with the highest count
//   winner_count count of the winning neuron
//   tie          another neuron equals the winner's (non-zero) count
//   no_spike     all counts were zero
//   rd_sel       readback select for the held counts
//   rd_count     combinational readback of count[rd_sel], 0 if out of range
module snn_spike_decoder #(
   parameter int unsigned N_OUT  = 8,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned WINDOW = 256,
   parameter int unsigned WIN_W  = 16,
   parameter int unsigned IDX_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N_OUT-1:0] out_spk,
   output logic             busy,
   output logic             result_valid,
   output logic [IDX_W-1:0] winner,
   output logic [CNT_W-1:0] winner_count,
   output logic             tie,
   output logic             no_spike,
   input  logic [IDX_W-1:0] rd_sel,
   output logic [CNT_W-1:0] rd_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COUNT   = 2'd1;
   localparam logic [1:0] S_COMPARE = 2'd2;

   // One extra bit so the scan index never wraps, even for N_OUT = 1.
   localparam int unsigned SCAN_W = IDX_W + 1;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [CNT_W-1:0]  cnt      [N_OUT];
   logic [CNT_W-1:0]  cnt_next [N_OUT];
   logic [WIN_W-1:0]  win_cnt;
   logic [SCAN_W-1:0] scan_idx;
   logic [IDX_W-1:0]  best_idx;
   logic [CNT_W-1:0]  best_cnt;
   logic              tie_acc;
   logic              win_last;
   logic              scan_last;
   logic [CNT_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]  cmp_idx;
   logic [CNT_W-1:0]  cmp_cnt;
   logic              cmp_tie;

   // Saturating per-neuron increment for the current sample.
   always_comb begin
      for (int i = 0; i < int'(N_OUT); i++) begin
         cnt_next[i] = cnt[i];
         if (out_spk[i] && (cnt[i] != {CNT_W{1'b1}}))
            cnt_next[i] = cnt[i] + CNT_W'(1);
      end
   end

   // One argmax step: compare the scanned neuron against the running best.
   always_comb begin
      win_last  = (win_cnt == WIN_W'(WINDOW - 1));
      scan_last = (scan_idx >= SCAN_W'(N_OUT - 1));
      scan_cnt  = '0;
      for (int i = 0; i < int'(N_OUT); i++)
         if (scan_idx == SCAN_W'(i))
            scan_cnt = cnt[i];
      cmp_idx = best_idx;
      cmp_cnt = best_cnt;
      cmp_tie = tie_acc;
      // Guard keeps a single-neuron build from comparing a phantom index.
      if (scan_idx < SCAN_W'(N_OUT)) begin
         if (scan_cnt > best_cnt) begin
            cmp_idx = IDX_W'(scan_idx);
            cmp_cnt = scan_cnt;
            cmp_tie = 1'b0;
         end else if (scan_cnt == best_cnt) begin
            cmp_tie = 1'b1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start)     state_next = S_COUNT;
         S_COUNT:   if (win_last)  state_next = S_COMPARE;
         S_COMPARE: if (scan_last) state_next = S_IDLE;
         default:                  state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Counters, argmax accumulators and registered result fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(N_OUT); i++) cnt[i] <= '0;
         win_cnt      <= '0;
         scan_idx     <= '0;
         best_idx     <= '0;
         best_cnt     <= '0;
         tie_acc      <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         winner       <= '0;
         winner_count <= '0;
         tie          <= 1'b0;
         no_spike     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         busy         <= (state_next != S_IDLE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < int'(N_OUT); i++) cnt[i] <= '0;
                  win_cnt <= '0;
               end
            end
            S_COUNT: begin
               for (int i = 0; i < int'(N_OUT); i++) cnt[i] <= cnt_next[i];
               win_cnt <= win_cnt + WIN_W'(1);
               // Seed with neuron 0 including the final sample of the window.
               if (win_last) begin
                  best_idx <= '0;
                  best_cnt <= cnt_next[0];
                  tie_acc  <= 1'b0;
                  scan_idx <= SCAN_W'(1);
               end
            end
            S_COMPARE: begin
               best_idx <= cmp_idx;
               best_cnt <= cmp_cnt;
               tie_acc  <= cmp_tie;
               scan_idx <= scan_idx + SCAN_W'(1);
               if (scan_last) begin
                  winner       <= cmp_idx;
                  winner_count <= cmp_cnt;
                  tie          <= cmp_tie && (cmp_cnt != '0);
                  no_spike     <= (cmp_cnt == '0);
                  result_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Readback mux; unselected or out-of-range indices read as zero.
   always_comb begin
      rd_count = '0;
      for (int i = 0; i < int'(N_OUT); i++)
         if (rd_sel == IDX_W'(i))
            rd_count = cnt[i];
   end

endmodule
